// File: rtl/riscv_wb_sched.sv
// riscv_wb_sched: writeback scheduler and register scoreboard.
// Shares the single regfile write port (rd0) between NUM_SRC
// producers with round-robin valid/ready arbitration and one
// registered stage; tracks in-flight destinations for stalls.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   src_valid_i/ready_o per-producer handshake (ready one-hot)
//   src_rd_i/value_i    packed dest reg / result per producer
//   rd0_o, rd0_value_o  regfile write index (0 = none) and data
//   issue_valid_i/rd_i  dispatched instruction marks rd pending
//   chk_ra/rb/rd_i      operands of the instruction waiting
//   stall_o, pending_o  hazard flag and scoreboard bitmap
module riscv_wb_sched #(
    parameter int NUM_SRC = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_SRC-1:0]    src_valid_i,
    input  logic [5*NUM_SRC-1:0]  src_rd_i,
    input  logic [32*NUM_SRC-1:0] src_value_i,
    output logic [NUM_SRC-1:0]    src_ready_o,
    output logic [4:0]            rd0_o,
    output logic [31:0]           rd0_value_o,
    input  logic                  issue_valid_i,
    input  logic [4:0]            issue_rd_i,
    input  logic [4:0]            chk_ra_i,
    input  logic [4:0]            chk_rb_i,
    input  logic [4:0]            chk_rd_i,
    output logic                  stall_o,
    output logic [31:0]           pending_o
);

    localparam int PTR_W = $clog2(NUM_SRC);

    logic [PTR_W-1:0] rr_q;
    logic [PTR_W-1:0] rr_d;
    logic [PTR_W-1:0] gnt_idx;
    logic             found;
    int               scan_idx;

    logic [4:0]       rd_arr  [NUM_SRC];
    logic [31:0]      val_arr [NUM_SRC];
    logic [4:0]       sel_rd;
    logic [31:0]      sel_val;

    logic [31:0]      pend_q;
    logic [31:0]      pend_d;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            rd_arr[i]  = src_rd_i[5*i +: 5];
            val_arr[i] = src_value_i[32*i +: 32];
        end
    end

    // Scan from rr_q upward with wrap; the first valid wins.
    always_comb begin
        found    = 1'b0;
        gnt_idx  = '0;
        scan_idx = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            scan_idx = int'(rr_q) + i;
            if (scan_idx >= NUM_SRC) begin
                scan_idx = scan_idx - NUM_SRC;
            end
            if (!found && src_valid_i[PTR_W'(scan_idx)]) begin
                found   = 1'b1;
                gnt_idx = PTR_W'(scan_idx);
            end
        end
    end

    always_comb begin
        src_ready_o = '0;
        if (found && !rst_i) begin
            src_ready_o[gnt_idx] = 1'b1;
        end
    end

    assign sel_rd  = rd_arr[gnt_idx];
    assign sel_val = val_arr[gnt_idx];

    assign rr_d = (gnt_idx == PTR_W'(NUM_SRC - 1))
                ? '0
                : gnt_idx + 1'b1;

    // Clear for the write leaving now, then set for the new
    // issue so a newer producer of the same reg stays tracked.
    always_comb begin
        pend_d = pend_q;
        if (rd0_o != 5'd0) begin
            pend_d[rd0_o] = 1'b0;
        end
        if (issue_valid_i && issue_rd_i != 5'd0) begin
            pend_d[issue_rd_i] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q        <= '0;
            rd0_o       <= '0;
            rd0_value_o <= '0;
            pend_q      <= '0;
        end else begin
            pend_q <= pend_d;
            if (found) begin
                rr_q        <= rr_d;
                rd0_o       <= sel_rd;
                rd0_value_o <= sel_val;
            end else begin
                rd0_o       <= '0;
                rd0_value_o <= '0;
            end
        end
    end

    // The register being written this cycle is still pending:
    // the read port returns the old value until the edge.
    assign stall_o = !rst_i
                   & (pend_q[chk_ra_i]
                    | pend_q[chk_rb_i]
                    | pend_q[chk_rd_i]);

    assign pending_o = pend_q;

    always @(posedge clk_i) begin
        if (!rst_i) begin
            a_one_ready: assert ($onehot0(src_ready_o))
                else $error("more than one src_ready_o");
            if (rd0_o != 5'd0) begin
                a_wr_pend: assert (pend_q[rd0_o])
                    else $error("write to non-pending rd");
            end
        end
    end

endmodule

// File: tb/tb_riscv_wb_sched.sv
// tb_riscv_wb_sched: randomized scoreboard bench for
// riscv_wb_sched with a queue-based reference model.
module tb_riscv_wb_sched;

    localparam int N = 3;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N-1:0]    src_valid_i;
    logic [5*N-1:0]  src_rd_i;
    logic [32*N-1:0] src_value_i;
    logic [N-1:0]    src_ready_o;
    logic [4:0]      rd0_o;
    logic [31:0]     rd0_value_o;
    logic            issue_valid_i;
    logic [4:0]      issue_rd_i;
    logic [4:0]      chk_ra_i;
    logic [4:0]      chk_rb_i;
    logic [4:0]      chk_rd_i;
    logic            stall_o;
    logic [31:0]     pending_o;

    always #5 clk_i = ~clk_i;

    riscv_wb_sched #(.NUM_SRC(N)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .src_valid_i   (src_valid_i),
        .src_rd_i      (src_rd_i),
        .src_value_i   (src_value_i),
        .src_ready_o   (src_ready_o),
        .rd0_o         (rd0_o),
        .rd0_value_o   (rd0_value_o),
        .issue_valid_i (issue_valid_i),
        .issue_rd_i    (issue_rd_i),
        .chk_ra_i      (chk_ra_i),
        .chk_rb_i      (chk_rb_i),
        .chk_rd_i      (chk_rd_i),
        .stall_o       (stall_o),
        .pending_o     (pending_o)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
    } item_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        logic [31:0] pend;
    } exp_t;

    // Producer FIFOs, expected-output queue, model state.
    item_t       prod_q [N][$];
    exp_t        exp_q[$];
    int          rr_m;
    logic [31:0] mp;
    logic [4:0]  m_rd0;
    int          vectors;
    int          miscompares;
    int          cyc;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h want %h",
                     name, cyc, act, req);
        end
    endtask

    task automatic push(input int s,
                        input logic [4:0] rd,
                        input logic [31:0] v);
        item_t it;
        it.rd  = rd;
        it.val = v;
        prod_q[s].push_back(it);
    endtask

    function automatic bit any_queued();
        bit r;
        r = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (prod_q[i].size() > 0) r = 1'b1;
        end
        return r;
    endfunction

    // One clock cycle: drive, check comb outputs, advance model.
    task automatic step(input bit rst,
                        input bit iv,
                        input logic [4:0] ird,
                        input logic [4:0] ca,
                        input logic [4:0] cb,
                        input logic [4:0] cd);
        int          g;
        int          idx;
        logic [N-1:0] er;
        item_t       it;
        exp_t        e;
        bit          st;
        @(negedge clk_i);
        cyc++;
        rst_i         = rst;
        issue_valid_i = iv;
        issue_rd_i    = ird;
        chk_ra_i      = ca;
        chk_rb_i      = cb;
        chk_rd_i      = cd;
        for (int i = 0; i < N; i++) begin
            if (prod_q[i].size() > 0) begin
                src_valid_i[i]         = 1'b1;
                src_rd_i[5*i +: 5]     = prod_q[i][0].rd;
                src_value_i[32*i +: 32] = prod_q[i][0].val;
            end else begin
                src_valid_i[i]          = 1'b0;
                src_rd_i[5*i +: 5]      = 5'($urandom);
                src_value_i[32*i +: 32] = $urandom;
            end
        end
        #1;
        g = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                idx = (rr_m + k) % N;
                if (g < 0 && prod_q[idx].size() > 0) g = idx;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("ready", 32'(src_ready_o), 32'(er));
        st = !rst && (mp[ca] || mp[cb] || mp[cd]);
        check("stall", 32'(stall_o), 32'(st));
        if (rst) begin
            mp    = '0;
            rr_m  = 0;
            m_rd0 = '0;
            e.rd  = '0;
            e.val = '0;
        end else begin
            it.rd  = '0;
            it.val = '0;
            if (g >= 0) begin
                it   = prod_q[g].pop_front();
                rr_m = (g + 1) % N;
            end
            if (m_rd0 != 5'd0) mp[m_rd0] = 1'b0;
            if (iv && ird != 5'd0) mp[ird] = 1'b1;
            m_rd0 = it.rd;
            e.rd  = it.rd;
            e.val = it.val;
        end
        e.pend = mp;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        end
    endtask

    // Monitor: each edge's registered outputs against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rd0", 32'(rd0_o), 32'(e.rd));
                check("rd0_value", rd0_value_o, e.val);
                check("pending", pending_o, e.pend);
            end
        end
    end

    initial begin
        bit         rst;
        bit         iv;
        logic [4:0] rd;
        int         n;
        vectors       = 0;
        miscompares   = 0;
        cyc           = 0;
        rr_m          = 0;
        mp            = '0;
        m_rd0         = '0;
        rst_i         = 1'b1;
        src_valid_i   = '0;
        src_rd_i      = '0;
        src_value_i   = '0;
        issue_valid_i = 1'b0;
        issue_rd_i    = '0;
        chk_ra_i      = '0;
        chk_rb_i      = '0;
        chk_rd_i      = '0;

        // Reset with all producers valid (x0 items drain after).
        for (int i = 0; i < N; i++) push(i, 5'd0, 32'h100 + i);
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        idle(5);

        // Single write through producer 0.
        step(1'b0, 1'b1, 5'd5, 5'd0, 5'd0, 5'd0);
        push(0, 5'd5, 32'hDEADBEEF);
        idle(4);

        // Round-robin with all three continuously valid.
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        for (int r = 10; r < 16; r++) begin
            step(1'b0, 1'b1, 5'(r), 5'd0, 5'd0, 5'd0);
        end
        for (int r = 10; r < 16; r++) begin
            push((r - 10) % N, 5'(r), 32'hA000 + r);
        end
        idle(9);

        // RAW hazard on x7 written back through producer 1.
        step(1'b0, 1'b1, 5'd7, 5'd0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 5'd0);
        push(1, 5'd7, 32'h0707_0707);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 5'd0);
        end

        // Set and clear of x9 on the same edge.
        step(1'b0, 1'b1, 5'd9, 5'd0, 5'd0, 5'd0);
        push(0, 5'd9, 32'h9999_0001);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        step(1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd9, 5'd0);
        push(2, 5'd9, 32'h9999_0002);
        idle(4);

        // x0 is never tracked.
        step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0);
        push(2, 5'd0, 32'h0BAD_0000);
        idle(4);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            iv  = 1'b0;
            rd  = 5'($urandom_range(1, 31));
            if ($urandom_range(0, 1) == 1 && !mp[rd]) iv = 1'b1;
            step(rst, iv, iv ? rd : 5'($urandom),
                 5'($urandom), 5'($urandom), 5'($urandom));
            if (rst) begin
                for (int i = 0; i < N; i++) prod_q[i].delete();
            end else begin
                if (iv) push($urandom_range(0, N - 1), rd, $urandom);
                if ($urandom_range(0, 15) == 0) begin
                    push($urandom_range(0, N - 1), 5'd0, $urandom);
                end
            end
        end

        n = 0;
        while (any_queued() && n < 500) begin
            idle(1);
            n++;
        end
        check("drain", 32'(any_queued()), 32'd0);
        idle(3);
        @(posedge clk_i);
        #3;
        check("exp_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
